bxu_io_port: RTL and testbench

//  Device-side end of the BXU io handshake: feeds bytes to the core's `in` instruction and accepts bytes from its `out` instruction.

---
 rtl/bxu_io_port.sv | 185 ++++++++++++++++++
 tb/tb_bxu_io_port.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bxu_io_port.sv
// bxu_io_port
//   Device-side end of the BXU io handshake. Bytes from a host stream are
//   queued in an RX FIFO and handed to the core's `in` instruction; bytes
//   from the core's `out` instruction are captured into a TX FIFO and
//   offered back to the host as a stream.
//
// Handshakes:
//   rx_valid/rx_ready, tx_valid/tx_ready: a byte moves at a posedge where
//   valid and ready are both high. valid never waits on ready. Data is
//   stable while valid is high and not yet accepted.
//   io_input_ready/io_input_done: the core consumes one byte per rising edge
//   of io_input_done. io_output_ready/io_output_done: one capture per request
//   level, acknowledged with a single-cycle io_output_done pulse.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   io_input_data/ready/done       core input side (head of RX FIFO)
//   io_output_data/ready/done      core output side (into TX FIFO)
//   rx_data/rx_valid/rx_ready      host -> RX FIFO
//   tx_data/tx_valid/tx_ready      TX FIFO -> host
//   rx_level, tx_level             FIFO occupancy, only when
//                                  BXU_IO_PORT_LEVEL_EN is defined
//
// Debug: tx_state holds the TX FSM state (IDLE/ACK/REARM) for probing.
module bxu_io_port #(
    parameter int DATA_BITWIDTH   = 8,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [DATA_BITWIDTH-1:0] io_input_data,
    output logic                     io_input_ready,
    input  logic                     io_input_done,
    input  logic [DATA_BITWIDTH-1:0] io_output_data,
    input  logic                     io_output_ready,
    output logic                     io_output_done,
    input  logic [DATA_BITWIDTH-1:0] rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [DATA_BITWIDTH-1:0] tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready
`ifdef BXU_IO_PORT_LEVEL_EN
    ,
    output logic [FIFO_DEPTH_LOG2:0] rx_level,
    output logic [FIFO_DEPTH_LOG2:0] tx_level
`endif
);

    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACK   = 2'd1;
    localparam logic [1:0] REARM = 2'd2;

    // ---------------------------------------------------------------- RX FIFO
    logic [DATA_BITWIDTH-1:0] rx_mem [DEPTH];
    logic [PW:0]              rx_wptr;
    logic [PW:0]              rx_rptr;
    logic                     rx_empty;
    logic                     rx_full;
    logic                     rx_push;
    logic                     rx_pop;
    logic                     done_q;
    logic                     done_rise;

    // Pointers carry one extra wrap bit: equal -> empty, differ only in the
    // wrap bit -> full.
    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[PW] != rx_rptr[PW]) &&
                      (rx_wptr[PW-1:0] == rx_rptr[PW-1:0]);

    // Only the rising edge of io_input_done consumes, so a held level pops once.
    assign done_rise = io_input_done & ~done_q;
    assign rx_push   = rx_valid & ~rx_full;
    assign rx_pop    = done_rise & ~rx_empty;

    // rx_ready looks only at fullness; a same-cycle pop does not free a slot.
    assign rx_ready       = ~rx_full;
    assign io_input_ready = ~rx_empty;
    // Gate the head with empty so the output is 0 out of reset and when drained.
    assign io_input_data  = rx_empty ? '0 : rx_mem[rx_rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wptr[PW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= io_input_done;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        end
    end

    // ---------------------------------------------------------------- TX FIFO
    logic [DATA_BITWIDTH-1:0] tx_mem [DEPTH];
    logic [PW:0]              tx_wptr;
    logic [PW:0]              tx_rptr;
    logic                     tx_empty;
    logic                     tx_full;
    logic                     tx_push;
    logic                     tx_pop;
    logic [1:0]               tx_state;
    logic [1:0]               tx_state_next;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[PW] != tx_rptr[PW]) &&
                      (tx_wptr[PW-1:0] == tx_rptr[PW-1:0]);

    assign tx_push  = (tx_state == IDLE) & io_output_ready & ~tx_full;
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_empty ? '0 : tx_mem[tx_rptr[PW-1:0]];

    assign io_output_done = (tx_state == ACK);

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr[PW-1:0]] <= io_output_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
        end
    end

    // ------------------------------------------------------------ TX FSM
    // IDLE captures once room exists; ACK pulses done; REARM waits for the
    // core to drop its request so a held level never captures twice.
    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            IDLE:    if (tx_push) tx_state_next = ACK;
            ACK:     tx_state_next = REARM;
            REARM:   if (!io_output_ready) tx_state_next = IDLE;
            default: tx_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= IDLE;
        end else begin
            tx_state <= tx_state_next;
        end
    end

`ifdef BXU_IO_PORT_LEVEL_EN
    // ------------------------------------------------------- occupancy
    localparam logic [PW:0] LVL_ONE = 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_level <= '0;
            tx_level <= '0;
        end else begin
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + LVL_ONE;
                2'b01:   rx_level <= rx_level - LVL_ONE;
                default: rx_level <= rx_level;
            endcase
            case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + LVL_ONE;
                2'b01:   tx_level <= tx_level - LVL_ONE;
                default: tx_level <= tx_level;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_bxu_io_port.sv
// tb_bxu_io_port
//   Directed bench for bxu_io_port. Drivers push expected bytes into
//   exp_rx_q / exp_tx_q; monitors pop and compare whenever the DUT hands a
//   byte to the core (io_input_done rise) or to the host (tx_valid&tx_ready).
module tb_bxu_io_port;

    localparam int DW = 8;
    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] io_input_data;
    logic          io_input_ready;
    logic          io_input_done = 1'b0;
    logic [DW-1:0] io_output_data = '0;
    logic          io_output_ready = 1'b0;
    logic          io_output_done;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
`ifdef BXU_IO_PORT_LEVEL_EN
    logic [NL:0]   rx_level;
    logic [NL:0]   tx_level;
`endif

    bxu_io_port #(.DATA_BITWIDTH(DW), .FIFO_DEPTH_LOG2(NL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .io_input_data  (io_input_data),
        .io_input_ready (io_input_ready),
        .io_input_done  (io_input_done),
        .io_output_data (io_output_data),
        .io_output_ready(io_output_ready),
        .io_output_done (io_output_done),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
`ifdef BXU_IO_PORT_LEVEL_EN
        ,
        .rx_level       (rx_level),
        .tx_level       (tx_level)
`endif
    );

    // ---------------------------------------------------- clock
    always #5 clk = ~clk;

    // ---------------------------------------------------- scoreboard state
    logic [DW-1:0] exp_rx_q[$];
    logic [DW-1:0] exp_tx_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            rx_pops = 0;
    int            done_count = 0;
    logic          mon_done_q = 1'b0;
    logic [DW-1:0] rx_exp_b;
    logic [DW-1:0] tx_exp_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Core-side monitor: a rising io_input_done with data present consumes the head.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_done_q <= 1'b0;
        end else begin
            if (io_input_done && !mon_done_q && io_input_ready) begin
                rx_pops++;
                if (exp_rx_q.size() == 0) begin
                    check("rx_unexpected_byte", {24'd0, io_input_data}, 32'hFFFF_FFFF);
                end else begin
                    rx_exp_b = exp_rx_q.pop_front();
                    check("rx_byte", {24'd0, io_input_data}, {24'd0, rx_exp_b});
                end
            end
            mon_done_q <= io_input_done;
        end
    end

    // Host-side monitor.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (exp_tx_q.size() == 0) begin
                check("tx_unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                tx_exp_b = exp_tx_q.pop_front();
                check("tx_byte", {24'd0, tx_data}, {24'd0, tx_exp_b});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && io_output_done) done_count++;
    end

    // ---------------------------------------------------- drivers
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_push(input logic [DW-1:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        exp_rx_q.push_back(b);
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic done_pulse();
        io_input_done = 1'b1;
        cyc();
        io_input_done = 1'b0;
        cyc();
    endtask

    // One core `out` request; waits (bounded) for the ack, then drops the
    // request long enough for the FSM to rearm.
    task automatic core_out(input logic [DW-1:0] b);
        bit seen;
        seen = 1'b0;
        io_output_data  = b;
        io_output_ready = 1'b1;
        exp_tx_q.push_back(b);
        for (int k = 0; k < 20 && !seen; k++) begin
            cyc();
            if (io_output_done) seen = 1'b1;
        end
        if (!seen) check("core_out_timeout", 32'd0, 32'd1);
        io_output_ready = 1'b0;
        cyc();
        cyc();
    endtask

    // ---------------------------------------------------- stimulus
    initial begin
        int base;

        // Reset values
        #12;
        @(negedge clk);
        check("rst_io_input_ready", {31'd0, io_input_ready}, 32'd0);
        check("rst_io_output_done", {31'd0, io_output_done}, 32'd0);
        check("rst_rx_ready",       {31'd0, rx_ready}, 32'd1);
        check("rst_tx_valid",       {31'd0, tx_valid}, 32'd0);
        check("rst_io_input_data",  {24'd0, io_input_data}, 32'd0);
        check("rst_tx_data",        {24'd0, tx_data}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: two bytes through RX, consumed by two done pulses
        rx_push(8'h41);
        rx_push(8'h42);
        @(negedge clk);
        check("t1_input_ready", {31'd0, io_input_ready}, 32'd1);
        check("t1_head", {24'd0, io_input_data}, 32'h41);
        cyc();
        done_pulse();
        done_pulse();
        @(negedge clk);
        check("t1_input_ready_after", {31'd0, io_input_ready}, 32'd0);
        check("t1_pops", rx_pops, 32'd2);

        // 2: held done pops exactly once
        cyc();
        rx_push(8'h10);
        rx_push(8'h11);
        rx_push(8'h12);
        base = rx_pops;
        io_input_done = 1'b1;
        repeat (5) cyc();
        io_input_done = 1'b0;
        cyc();
        @(negedge clk);
        check("t2_single_pop", rx_pops - base, 32'd1);
        check("t2_remaining", exp_rx_q.size(), 32'd2);
        check("t2_head", {24'd0, io_input_data}, 32'h11);
`ifdef BXU_IO_PORT_LEVEL_EN
        check("t2_rx_level", {27'd0, rx_level}, 32'd2);
`endif
        cyc();
        done_pulse();
        done_pulse();
        @(negedge clk);
        check("t2_drained", {31'd0, io_input_ready}, 32'd0);

        // 3: level held 4 cycles -> one done, one cycle after capture
        cyc();
        base = done_count;
        io_output_data  = 8'h5A;
        io_output_ready = 1'b1;
        exp_tx_q.push_back(8'h5A);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_done_timing", {31'd0, io_output_done}, (k == 1) ? 32'd1 : 32'd0);
        end
        cyc();
        io_output_ready = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        check("t3_done_count", done_count - base, 32'd1);
        check("t3_tx_valid", {31'd0, tx_valid}, 32'd1);
        check("t3_tx_data", {24'd0, tx_data}, 32'h5A);

        // 4: fill TX, stall while full, one host pop releases the capture
        cyc();
        for (int i = 0; i < 15; i++) core_out(8'h60 + 8'(i));
        io_output_data  = 8'h77;
        io_output_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_full_stall", {31'd0, io_output_done}, 32'd0);
        end
        cyc();
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        @(negedge clk);
        check("t4_no_done_yet", {31'd0, io_output_done}, 32'd0);
        cyc();
        @(negedge clk);
        check("t4_done_after_pop", {31'd0, io_output_done}, 32'd1);
        exp_tx_q.push_back(8'h77);
        cyc();
        io_output_ready = 1'b0;
        cyc();
        cyc();
        tx_ready = 1'b1;
        repeat (16) cyc();
        tx_ready = 1'b0;
        @(negedge clk);
        check("t4_tx_empty", {31'd0, tx_valid}, 32'd0);
        check("t4_tx_q_used", exp_tx_q.size(), 32'd0);

        // 5: fill RX with rx_valid held; 17th byte refused
        cyc();
        rx_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rx_data = 8'h80 + 8'(i);
            if (i < 16) exp_rx_q.push_back(rx_data);
            @(negedge clk);
            check("t5_rx_ready_fill", {31'd0, rx_ready}, (i < 16) ? 32'd1 : 32'd0);
            cyc();
        end
        // pop while full: rx_ready stays low that cycle, the held byte is not taken
        io_input_done = 1'b1;
        @(negedge clk);
        check("t5_full_with_pop", {31'd0, rx_ready}, 32'd0);
        cyc();
        rx_valid = 1'b0;
        io_input_done = 1'b0;
        cyc();
        @(negedge clk);
        check("t5_ready_after_pop", {31'd0, rx_ready}, 32'd1);
        cyc();
        for (int i = 0; i < 7; i++) done_pulse();
`ifdef BXU_IO_PORT_LEVEL_EN
        @(negedge clk);
        check("t5_rx_level_8", {27'd0, rx_level}, 32'd8);
        cyc();
`endif
        // simultaneous push and pop at count 8
        rx_data  = 8'hC0;
        rx_valid = 1'b1;
        io_input_done = 1'b1;
        exp_rx_q.push_back(8'hC0);
        cyc();
        rx_valid = 1'b0;
        io_input_done = 1'b0;
        cyc();
`ifdef BXU_IO_PORT_LEVEL_EN
        @(negedge clk);
        check("t5_rx_level_still_8", {27'd0, rx_level}, 32'd8);
        cyc();
`endif
        for (int i = 0; i < 8; i++) done_pulse();
        @(negedge clk);
        check("t5_rx_empty", {31'd0, io_input_ready}, 32'd0);
        check("t5_rx_q_used", exp_rx_q.size(), 32'd0);

        // 6: reset mid-operation
        cyc();
        for (int i = 0; i < 5; i++) rx_push(8'h20 + 8'(i));
        io_output_data  = 8'h33;
        io_output_ready = 1'b1;
        cyc();
        @(negedge clk);
        check("t6_in_ack", {31'd0, io_output_done}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_io_output_done", {31'd0, io_output_done}, 32'd0);
        check("t6_rst_io_input_ready", {31'd0, io_input_ready}, 32'd0);
        check("t6_rst_rx_ready",       {31'd0, rx_ready}, 32'd1);
        check("t6_rst_tx_valid",       {31'd0, tx_valid}, 32'd0);
        check("t6_rst_io_input_data",  {24'd0, io_input_data}, 32'd0);
        check("t6_rst_tx_data",        {24'd0, tx_data}, 32'd0);
`ifdef BXU_IO_PORT_LEVEL_EN
        check("t6_rst_rx_level", {27'd0, rx_level}, 32'd0);
        check("t6_rst_tx_level", {27'd0, tx_level}, 32'd0);
`endif
        exp_rx_q.delete();
        exp_tx_q.delete();
        io_output_ready = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // traffic resumes cleanly after reset
        base = rx_pops;
        rx_push(8'h21);
        done_pulse();
        core_out(8'h44);
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        @(negedge clk);
        check("t6_post_rx_pop", rx_pops - base, 32'd1);
        check("t6_post_tx_empty", {31'd0, tx_valid}, 32'd0);
        check("t6_queues_used", exp_rx_q.size() + exp_tx_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
